bus_waitstate_ctrl: RTL and testbench
=====================================

# bus_waitstate_ctrl

Parametrised wait-state and fault controller between the ARM7TDMI-S core bus and the simulation memories. It succeeds the fixed single-count pause generator with a programmable per-region table: N independent address regions, separate non-sequential (N) and sequential (S) wait counts, and GBA-style sequential-access detection. It also flags writes to read-only regions and accesses to unmapped addresses. It drives the core's PAUSE and ABORT inputs.

## Interface
- NUM_REGIONS, 4: number of address regions, at least 1.
- ADDR_W, 32: address width.
- CNT_W, 3: wait-count width; maximum wait is 2^CNT_W-1 cycles.
- SEQ_BOUNDARY_LOG2, 17: a sequential burst is broken at every 2^SEQ_BOUNDARY_LOG2-byte boundary (128 KiB).

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid  in  1  bus access presented this cycle; 0 means an internal cycle.
- addr  in  ADDR_W  access address.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- write  in  1  access is a write.
- rgn_start  in  NUM_REGIONS×ADDR_W  inclusive region base.
- rgn_end  in  NUM_REGIONS×ADDR_W  inclusive region limit.
- rgn_nwait  in  NUM_REGIONS×CNT_W  non-sequential wait cycles.
- rgn_swait  in  NUM_REGIONS×CNT_W  sequential wait cycles.
- rgn_ro  in  NUM_REGIONS  region is read-only.
- pause  out  1  stall the core.
- abort  out  1  the current access faulted.
- seq  out  1  the last accepted access was sequential.
- rgn_idx  out  $clog2(NUM_REGIONS)  region of the last accepted access.
- rgn_hit  out  1  the last accepted access mapped to a region.

## Operation
- **Acceptance:** an access is accepted on a posedge where valid=1 and pause=0. Inputs present while pause=1 are ignored, because the core holds them.
- **Decode:** the access hits region i when rgn_start[i] ≤ addr ≤ rgn_end[i]. If regions overlap, the lowest index wins. If no region matches, the access is unmapped.
- **Sequential test:** an accepted access is sequential when all of the following hold:
  - the previous accepted access was mapped;
  - no valid=0 cycle was accepted in between;
  - it is in the same region as the previous access;
  - addr == prev_addr + bytes(prev_size), with the sum truncated to ADDR_W;
  - addr[SEQ_BOUNDARY_LOG2-1:0] ≠ 0.
- **Wait load:** the down-counter loads rgn_swait if the access is sequential, else rgn_nwait. For an unmapped or reserved-size access it loads 0.
- **Fault:** the fault flag is set for an unmapped address, a reserved size, or a write to an rgn_ro region. A fault also clears the sequence history, so the next access is non-sequential.
- **Idle:** a valid=0 cycle with pause=0 clears the sequence history and clears abort.
- **Config changes:** rgn_* inputs are sampled only at acceptance. Changing them mid-wait does not affect the running count.
- **State machine:**
  - IDLE/ACCEPT → WAIT when the loaded count > 0.
  - WAIT → WAIT while count > 1, decrementing each cycle.
  - WAIT → IDLE/ACCEPT when count reaches 1 → 0.

## Timing
- Reset values: pause=0, abort=0, seq=0, rgn_idx=0, rgn_hit=0, counter=0, sequence history cleared.
- pause is registered (count ≠ 0). For an access accepted at edge T with wait w, pause is high from T until edge T+w, which is exactly w cycles. With w=0, pause never rises and the next access can be accepted at T+1.
- abort, seq, rgn_idx and rgn_hit update at the acceptance edge. They hold through the wait cycles and the data cycle, until the next acceptance or idle edge.
- Reset asserted mid-wait drops pause asynchronously. The first access after reset is always non-sequential.
- Back-to-back accesses: the next access is accepted on the edge where pause is already 0, so there is no dead cycle.

## Structure
- Shared package `bus_pkg`:
  - MEM_SIZE_BYTE/HALF/WORD/RESR encodings;
  - a size_bytes() function;
  - a region config struct (start, end, nwait, swait, ro) that the GBA memory-map constants populate.
- One sub-module, `wait_counter`: a CNT_W loadable down-counter with a zero flag.
- The region decode is a combinational loop inside the top module.

## Test plan
- **N then S access:** region 0 = 0x0800_0000–0x09FF_FFFF, nwait=3, swait=1; words at 0x0800_0000 then 0x0800_0004.
  - Expect pause for 3 cycles, then 1 cycle.
  - Expect seq = 0, then 1.
- **Sequence breakers:** in the same region, an access to 0x0800_0010 after 0x0800_0004 is non-sequential (3 waits). A valid=0 cycle between two consecutive words also forces 3 waits.
- **Boundary:** half accesses at 0x0801_FFFE then 0x0802_0000 → the second access is non-sequential, because of the 128 KiB boundary.
- **Faults:**
  - Word write to an rgn_ro region → abort=1, held until the next acceptance; the following access to the next address is non-sequential.
  - Read at an unmapped 0x1000_0000 → abort=1, rgn_hit=0, no pause.
- **Zero wait and overlap:**
  - nwait=0 → pause stays 0 across 4 back-to-back reads.
  - Two overlapping regions → rgn_idx reports the lower index.
- **Reset mid-wait:** assert rst_n=0 during a 5-cycle wait → pause=0 immediately, and the next access is non-sequential.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: bus size encodings, controller state type, region config type and GBA memory-map constants
package bus_pkg;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam logic [1:0] MEM_SIZE_RESR = 2'b11;
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] end_addr;
    logic [2:0] nwait;
    logic [2:0] swait;
    logic ro;
  } rgn_cfg_t;
  localparam rgn_cfg_t GBA_BIOS  = '{32'h0000_0000, 32'h0000_3FFF, 3'd1, 3'd0, 1'b1};
  localparam rgn_cfg_t GBA_EWRAM = '{32'h0200_0000, 32'h0203_FFFF, 3'd2, 3'd2, 1'b0};
  localparam rgn_cfg_t GBA_IWRAM = '{32'h0300_0000, 32'h0300_7FFF, 3'd0, 3'd0, 1'b0};
  localparam rgn_cfg_t GBA_ROM0  = '{32'h0800_0000, 32'h09FF_FFFF, 3'd3, 3'd1, 1'b0};
  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    return s == MEM_SIZE_BYTE ? 3'd1 : s == MEM_SIZE_HALF ? 3'd2 : s == MEM_SIZE_WORD ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter that stops at zero and flags it
module wait_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= din;
    else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/bus_waitstate_ctrl.sv
// bus_waitstate_ctrl: per-region wait-state, sequential-access and fault controller driving core pause/abort
module bus_waitstate_ctrl
  import bus_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W = 3,
  parameter int SEQ_BOUNDARY_LOG2 = 17,
  localparam int IW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                valid,
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [1:0]                          size,
  input  logic                                write,
  input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]  rgn_start,
  input  logic [NUM_REGIONS-1:0][ADDR_W-1:0]  rgn_end,
  input  logic [NUM_REGIONS-1:0][CNT_W-1:0]   rgn_nwait,
  input  logic [NUM_REGIONS-1:0][CNT_W-1:0]   rgn_swait,
  input  logic [NUM_REGIONS-1:0]              rgn_ro,
  output logic                                pause,
  output logic                                abort,
  output logic                                seq,
  output logic [IW-1:0]                       rgn_idx,
  output logic                                rgn_hit
);
  state_t st;
  logic hit, hist, seq_now, bad, fault, zero;
  logic [IW-1:0] idx;
  logic [ADDR_W-1:0] prev_addr;
  logic [1:0] prev_size;
  logic [CNT_W-1:0] ld, cnt;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--)
      if (addr >= rgn_start[i] && addr <= rgn_end[i]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
  assign bad = !hit || size == MEM_SIZE_RESR;
  assign fault = bad || (write && rgn_ro[idx]);
  assign seq_now = hist && hit && idx == rgn_idx && addr == prev_addr + ADDR_W'(size_bytes(prev_size))
                   && addr[SEQ_BOUNDARY_LOG2-1:0] != '0;
  assign ld = bad ? '0 : seq_now ? rgn_swait[idx] : rgn_nwait[idx];
  wait_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .load(valid && zero),
    .din(ld),
    .cnt(cnt),
    .zero(zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= ST_IDLE;
      pause <= 1'b0;
      abort <= 1'b0;
      seq <= 1'b0;
      rgn_idx <= '0;
      rgn_hit <= 1'b0;
      hist <= 1'b0;
      prev_addr <= '0;
      prev_size <= MEM_SIZE_BYTE;
    end else if (st == ST_WAIT) begin
      if (cnt == CNT_W'(1)) begin
        st <= ST_IDLE;
        pause <= 1'b0;
      end
    end else if (valid) begin
      st <= ld != '0 ? ST_WAIT : ST_IDLE;
      pause <= ld != '0;
      abort <= fault;
      seq <= seq_now;
      rgn_idx <= idx;
      rgn_hit <= hit;
      hist <= !fault;
      prev_addr <= addr;
      prev_size <= size;
    end else begin
      hist <= 1'b0;
      abort <= 1'b0;
    end
endmodule

// File: tb/tb_bus_waitstate_ctrl.sv
// tb_bus_waitstate_ctrl: directed self-checking bench for bus_waitstate_ctrl
module tb_bus_waitstate_ctrl;
  import bus_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, write = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0] size = '0;
  logic [3:0][31:0] rgn_start, rgn_end;
  logic [3:0][2:0] rgn_nwait, rgn_swait;
  logic [3:0] rgn_ro;
  logic pause, abort, seq, rgn_hit;
  logic [1:0] rgn_idx;
  logic o_abort, o_seq, o_hit;
  logic [1:0] o_idx;
  int checks = 0, errors = 0, waits = 0;
  time t0;
  bus_waitstate_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid(valid),
    .addr(addr),
    .size(size),
    .write(write),
    .rgn_start(rgn_start),
    .rgn_end(rgn_end),
    .rgn_nwait(rgn_nwait),
    .rgn_swait(rgn_swait),
    .rgn_ro(rgn_ro),
    .pause(pause),
    .abort(abort),
    .seq(seq),
    .rgn_idx(rgn_idx),
    .rgn_hit(rgn_hit)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [31:0] a, input logic [1:0] s, input logic w);
    valid = 1'b1;
    addr = a;
    size = s;
    write = w;
    @(posedge clk);
    #1;
    o_abort = abort;
    o_seq = seq;
    o_hit = rgn_hit;
    o_idx = rgn_idx;
    waits = 0;
    while (pause && waits < 20) begin
      @(posedge clk);
      #1;
      waits++;
    end
  endtask
  task automatic acc(input string tag, input logic [31:0] a, input logic [1:0] s, input logic w,
                     input int ex_wait, input logic ex_seq, input logic ex_abort, input logic ex_hit,
                     input logic [1:0] ex_idx);
    step(a, s, w);
    chk({tag, ".wait"}, 32'(waits), 32'(ex_wait));
    chk({tag, ".seq"}, 32'(o_seq), 32'(ex_seq));
    chk({tag, ".abort"}, 32'(o_abort), 32'(ex_abort));
    chk({tag, ".hit"}, 32'(o_hit), 32'(ex_hit));
    chk({tag, ".idx"}, 32'(o_idx), 32'(ex_idx));
  endtask
  initial begin
    rgn_start[0] = 32'h0800_0000; rgn_end[0] = 32'h09FF_FFFF; rgn_nwait[0] = 3'd3; rgn_swait[0] = 3'd1; rgn_ro[0] = 1'b0;
    rgn_start[1] = 32'h0000_0000; rgn_end[1] = 32'h0000_3FFF; rgn_nwait[1] = 3'd1; rgn_swait[1] = 3'd0; rgn_ro[1] = 1'b1;
    rgn_start[2] = 32'h0300_0000; rgn_end[2] = 32'h0300_7FFF; rgn_nwait[2] = 3'd0; rgn_swait[2] = 3'd0; rgn_ro[2] = 1'b0;
    rgn_start[3] = 32'h0300_4000; rgn_end[3] = 32'h0300_4FFF; rgn_nwait[3] = 3'd2; rgn_swait[3] = 3'd2; rgn_ro[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pause", 32'(pause), 32'd0);
    chk("reset.abort", 32'(abort), 32'd0);
    chk("reset.seq", 32'(seq), 32'd0);
    chk("reset.idx", 32'(rgn_idx), 32'd0);
    chk("reset.hit", 32'(rgn_hit), 32'd0);
    rst_n = 1'b1;
    acc("ns.n",    32'h0800_0000, MEM_SIZE_WORD, 1'b0, 3, 1'b0, 1'b0, 1'b1, 2'd0);
    acc("ns.s",    32'h0800_0004, MEM_SIZE_WORD, 1'b0, 1, 1'b1, 1'b0, 1'b1, 2'd0);
    acc("brk.gap", 32'h0800_0010, MEM_SIZE_WORD, 1'b0, 3, 1'b0, 1'b0, 1'b1, 2'd0);
    acc("brk.s",   32'h0800_0014, MEM_SIZE_WORD, 1'b0, 1, 1'b1, 1'b0, 1'b1, 2'd0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    acc("brk.idle", 32'h0800_0018, MEM_SIZE_WORD, 1'b0, 3, 1'b0, 1'b0, 1'b1, 2'd0);
    acc("bnd.n",    32'h0801_FFFC, MEM_SIZE_HALF, 1'b0, 3, 1'b0, 1'b0, 1'b1, 2'd0);
    acc("bnd.s",    32'h0801_FFFE, MEM_SIZE_HALF, 1'b0, 1, 1'b1, 1'b0, 1'b1, 2'd0);
    acc("bnd.cross", 32'h0802_0000, MEM_SIZE_HALF, 1'b0, 3, 1'b0, 1'b0, 1'b1, 2'd0);
    acc("ro.write", 32'h0000_0000, MEM_SIZE_WORD, 1'b1, 1, 1'b0, 1'b1, 1'b1, 2'd1);
    chk("ro.hold", 32'(abort), 32'd1);
    acc("ro.next",  32'h0000_0004, MEM_SIZE_WORD, 1'b0, 1, 1'b0, 1'b0, 1'b1, 2'd1);
    acc("unmap",    32'h1000_0000, MEM_SIZE_WORD, 1'b0, 0, 1'b0, 1'b1, 1'b0, 2'd0);
    t0 = $time;
    acc("zw.0", 32'h0300_0000, MEM_SIZE_WORD, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2'd2);
    acc("zw.1", 32'h0300_0004, MEM_SIZE_WORD, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd2);
    acc("zw.2", 32'h0300_0008, MEM_SIZE_WORD, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd2);
    acc("zw.3", 32'h0300_000C, MEM_SIZE_WORD, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2'd2);
    chk("zw.span", 32'($time - t0), 32'd40);
    chk("zw.pause", 32'(pause), 32'd0);
    acc("overlap",  32'h0300_4000, MEM_SIZE_WORD, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2'd2);
    acc("resv",     32'h0800_0000, MEM_SIZE_RESR, 1'b0, 0, 1'b0, 1'b1, 1'b1, 2'd0);
    rgn_nwait[0] = 3'd5;
    valid = 1'b1;
    addr = 32'h0800_0100;
    size = MEM_SIZE_WORD;
    write = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.pause_on", 32'(pause), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.pause_off", 32'(pause), 32'd0);
    chk("rst.hit", 32'(rgn_hit), 32'd0);
    addr = 32'h0800_0104;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc("rst.next", 32'h0800_0104, MEM_SIZE_WORD, 1'b0, 5, 1'b0, 1'b0, 1'b1, 2'd0);
    acc("rst.seq",  32'h0800_0108, MEM_SIZE_WORD, 1'b0, 1, 1'b1, 1'b0, 1'b1, 2'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
